// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one 8-bit UART transmitter between
// NUM_REQ byte sources. The transmitter runs on a slower baud clock, so its
// busy/done levels are synchronised and the start/complete handshake is
// level-based. Each handshake phase is guarded by a timeout.

module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     ack,
  output logic                   tx_en,
  output logic                   tx_start,
  output logic [7:0]             tx_data,
  input  logic                   tx_busy,
  input  logic                   tx_done,
  output logic [2:0]             grant_id,
  output logic                   busy,
  output logic                   timeout
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  // Index reached by stepping 'offset' places up from 'base', wrapping at NUM_REQ.
  function automatic logic [2:0] wrap_idx(input logic [2:0] base, input int offset);
    int sum;
    sum = int'(base) + offset;
    return (sum >= NUM_REQ) ? 3'(sum - NUM_REQ) : 3'(sum);
  endfunction

  state_t           r_state;
  logic [2:0]       r_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy_meta;
  logic             r_busy_sync;
  logic             r_done_meta;
  logic             r_done_sync;
  logic [NUM_REQ-1:0] r_ack;
  logic             r_tx_en;
  logic             r_tx_start;
  logic [7:0]       r_tx_data;
  logic [2:0]       r_grant_id;
  logic             r_busy;
  logic             r_timeout;

  logic [7:0]       w_req_pad;
  logic [63:0]      w_data_pad;
  logic             w_found;
  logic [2:0]       w_idx;
  logic [2:0]       w_ptr_next;
  logic [7:0]       w_sel_byte;
  logic [7:0]       w_onehot;
  logic             w_leave;
  state_t           w_state_next;

  assign w_req_pad  = 8'(req);
  assign w_data_pad = 64'(req_data);

  // Round-robin pick: first asserted request at or above the pointer, wrapping.
  always_comb begin
    w_found = |req;
    w_idx   = 3'd0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = w_req_pad[wrap_idx(r_ptr, k)] ? wrap_idx(r_ptr, k) : w_idx;
    end
    w_ptr_next = (w_idx == 3'(NUM_REQ - 1)) ? 3'd0 : (w_idx + 3'd1);
    w_sel_byte = w_data_pad[{w_idx, 3'b000} +: 8];
    w_onehot   = 8'd1 << w_idx;
  end

  // Handshake progress decisions from the synchronised transmitter levels.
  always_comb begin
    w_leave      = 1'b0;
    w_state_next = r_state;
    case (r_state)
      ST_START: begin
        if (r_busy_sync || r_done_sync) begin
          w_leave      = 1'b1;
          w_state_next = ST_WAIT;
        end else begin
          w_leave      = 1'b0;
        end
      end
      ST_WAIT: begin
        if (r_done_sync || !r_busy_sync) begin
          w_leave      = 1'b1;
          w_state_next = ST_DRAIN;
        end else begin
          w_leave      = 1'b0;
        end
      end
      ST_DRAIN: begin
        // Wait for both levels to clear so a lingering done cannot start the next byte.
        if (!r_busy_sync && !r_done_sync) begin
          w_leave      = 1'b1;
          w_state_next = ST_IDLE;
        end else begin
          w_leave      = 1'b0;
        end
      end
      default: begin
        w_leave      = 1'b0;
        w_state_next = r_state;
      end
    endcase
  end

  // Two-flop synchronisers for the transmitter-domain busy and done levels.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy_meta <= 1'b0;
      r_busy_sync <= 1'b0;
      r_done_meta <= 1'b0;
      r_done_sync <= 1'b0;
    end else begin
      r_busy_meta <= tx_busy;
      r_busy_sync <= r_busy_meta;
      r_done_meta <= tx_done;
      r_done_sync <= r_done_meta;
    end
  end

  // Arbitration / handshake FSM with registered outputs and phase timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_ptr      <= 3'd0;
      r_cnt      <= '0;
      r_ack      <= '0;
      r_tx_en    <= 1'b0;
      r_tx_start <= 1'b0;
      r_tx_data  <= 8'd0;
      r_grant_id <= 3'd0;
      r_busy     <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_tx_en   <= 1'b1;
      r_ack     <= '0;
      r_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (w_found) begin
            r_tx_data  <= w_sel_byte;
            r_grant_id <= w_idx;
            r_ack      <= w_onehot[NUM_REQ-1:0];
            r_ptr      <= w_ptr_next;
            r_tx_start <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= ST_START;
          end else begin
            r_state    <= ST_IDLE;
          end
        end
        default: begin
          if (r_cnt == CNT_LAST) begin
            // Abort: the acked byte is dropped and the pointer keeps moving on.
            r_timeout  <= 1'b1;
            r_tx_start <= 1'b0;
            r_busy     <= 1'b0;
            r_cnt      <= '0;
            r_state    <= ST_IDLE;
          end else if (w_leave) begin
            r_tx_start <= 1'b0;
            r_busy     <= (w_state_next != ST_IDLE);
            r_cnt      <= '0;
            r_state    <= w_state_next;
          end else begin
            r_cnt      <= r_cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

  assign ack      = r_ack;
  assign tx_en    = r_tx_en;
  assign tx_start = r_tx_start;
  assign tx_data  = r_tx_data;
  assign grant_id = r_grant_id;
  assign busy     = r_busy;
  assign timeout  = r_timeout;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single 8-bit UART transmitter between NUM_REQ byte sources using round-robin arbitration.
- Sequences the transmitter handshake: it drives start and data, then waits for completion.
- Sits between the board logic (status/LED reporters, command responders) and the UART transmitter instance.
- Runs on the board clock; the transmitter runs on the slower baud-derived clock, so the handshake is level-based and tolerates the clock ratio.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- TIMEOUT_CYCLES, 200000, board-clock cycles allowed per handshake phase before the arbiter aborts.

Ports:
- clk  input  1  board clock.
- rst  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-requester byte-ready level; the requester holds it and its data until ack.
- req_data  input  8*NUM_REQ  packed bytes; requester i uses bits [8i+7:8i].
- ack  output  NUM_REQ  one-cycle pulse; the byte from requester i has been captured.
- tx_en  output  1  transmitter enable.
- tx_start  output  1  transmitter start level.
- tx_data  output  8  byte presented to the transmitter.
- tx_busy  input  1  transmitter busy (from transmitter clock domain).
- tx_done  input  1  transmitter done (from transmitter clock domain).
- grant_id  output  3  index of the requester currently being served.
- busy  output  1  high whenever state is not IDLE.
- timeout  output  1  one-cycle pulse when a handshake phase is aborted.

Behaviour:
- Input synchronisation: tx_busy and tx_done each pass through a 2-flop synchroniser; only the synchronised versions (busy_s, done_s) are used.
- Reset values, applied on rst at the rising clk edge:
  - ack=0, tx_start=0, tx_data=0, grant_id=0, busy=0, timeout=0.
  - State=IDLE, priority pointer=0, timeout counter=0.
  - Synchroniser flops=0.
  - tx_en=1 constantly after reset; it is 0 only while rst=1.
- State machine: IDLE, START, WAIT, DRAIN.
- IDLE:
  - If any req bit is high, select the first asserted index scanning upward from the pointer, wrapping at NUM_REQ-1 to 0.
  - On that edge: tx_data<=byte, grant_id<=index, ack[index]=1 for one cycle, go to START.
  - The pointer is updated to index+1 (mod NUM_REQ) at the same edge.
  - Grant latency: one clk from req high to ack, given IDLE.
- START: tx_start=1. Go to WAIT when busy_s=1 or done_s=1.
- WAIT: tx_start=0. Go to DRAIN when done_s=1 or busy_s=0.
- DRAIN: go to IDLE only when busy_s=0 and done_s=0. This prevents a stale done from re-triggering the next byte.
- Timeout:
  - The counter clears on every state change.
  - In START, WAIT or DRAIN, reaching TIMEOUT_CYCLES-1 pulses timeout for one cycle, forces tx_start=0 and returns to IDLE.
  - The pointer is not rolled back, so the aborted requester's byte is dropped (it was already acked).
- Rules for requesters and arbitration:
  - A req arriving while busy waits; there is no queueing inside the block.
  - req dropped before ack means nothing is sent and no ack is given.
  - Simultaneous requests are served in round-robin order; no requester waits more than NUM_REQ-1 grants.
  - req_data changes after ack have no effect; tx_data is registered and stable from ack until the next grant.
- Reset mid-operation: tx_start drops at the reset edge and any byte in flight is abandoned. The transmitter may finish its frame independently; DRAIN logic after reset is not required because state=IDLE and the pointer=0.

Test Plan:
- Single request: after reset, req=4'b0100 with req_data[23:16]=8'hA5 -> ack=4'b0100 one cycle later, grant_id=2, tx_data=8'hA5, tx_start held until busy_s=1, then busy returns low after done.
- All four requesting continuously, bytes 8'h10/8'h11/8'h12/8'h13 -> serial order 10,11,12,13,10,... with exactly one ack per byte.
- Priority rotation: serve req 3, then raise req 0 and 3 together -> 0 is granted first (pointer wrapped to 0).
- Stuck transmitter: tx_busy held 0 with TIMEOUT_CYCLES=50 -> timeout pulses 50 cycles after entering START, tx_start falls, state is IDLE, and the next request is granted normally.
- Lingering done: tx_done held high for 3000 clk after the frame -> no second byte starts until done_s falls (DRAIN held).
- Reset asserted during WAIT -> next cycle tx_start=0, busy=0, ack=0, grant_id=0; a subsequent req from requester 1 is granted with a normal 1-cycle latency.
